ps2_key_event_rx: RTL

- Parametrised PS/2 keyboard receiver; successor to the current keyboard driver.
- Takes the raw PS2CLK/PS2DATA lines and validates every 11-bit frame (start, odd parity, stop, timeout).
- Folds E0/F0 prefixes into one key event word: make/break and extended flags plus the 8-bit code.
- Buffers events in a FIFO drained by a valid/ready handshake, and drives a configurable interrupt (pulse or level) to the OTTER.

---
 rtl/ps2_key_event_rx_pkg.sv | 18 +
 rtl/ps2_key_event_rx_if.sv | 11 +
 rtl/ps2_frame_rx.sv | 96 +++++++++
 rtl/ps2_key_event_rx.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ps2_key_event_rx_pkg.sv
// Shared types and byte constants for the PS/2 key event receiver.
package ps2_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;
endpackage

// File: rtl/ps2_key_event_rx_if.sv
// Event stream between the key receiver (master) and its consumer (slave).
interface ps2_key_event_rx_if;
    import ps2_pkg::*;

    logic     evt_valid;
    logic     evt_ready;
    key_evt_t evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame capture with framing, parity and timeout checks.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       PS2CLK,
    input  logic       PS2DATA,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt;
    logic [FW-1:0] filt_cnt;
    logic          busy;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] timer;
    logic          fall;
    logic [10:0]   frame;
    logic          good;

    // The filtered clock drops in the same cycle this pulse is seen.
    assign fall  = filt && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));
    assign frame = {dat_sync[1], shreg};
    assign good  = !frame[0] && (^frame[9:1]) && frame[10];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], PS2CLK};
            dat_sync <= {dat_sync[0], PS2DATA};
            if (clk_sync[1] == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt     <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                timer <= TW'(TIMEOUT_CYCLES - 1);
                if (!busy) begin
                    busy    <= 1'b1;
                    bit_cnt <= 4'd1;
                    shreg   <= {dat_sync[1], shreg[9:1]};
                end else if (bit_cnt == 4'd10) begin
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    if (good) begin
                        byte_valid <= 1'b1;
                        byte_data  <= frame[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {dat_sync[1], shreg[9:1]};
                end
            end else if (busy) begin
                if (timer == '0) begin
                    busy      <= 1'b0;
                    bit_cnt   <= '0;
                    frame_err <= 1'b1;
                end else begin
                    timer <= timer - TW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events, buffers them and raises INTRPT.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int INTR_MODE      = 0,
    parameter int INTR_CYCLES    = 8
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      PS2CLK,
    input  logic                      PS2DATA,
    ps2_key_event_rx_if.master        evt,
    output logic                      INTRPT,
    output logic                      overflow,
    input  logic                      ovf_clr,
    output logic [7:0]                err_count
);
    // state      | meaning
    // ST_IDLE    | no prefix pending
    // ST_EXT     | E0 seen
    // ST_BRK     | F0 seen
    // ST_EXT_BRK | E0 F0 seen
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(INTR_CYCLES + 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    dec_state_t state;
    logic       push_q;
    key_evt_t   push_evt;

    key_evt_t      mem [FIFO_DEPTH];
    key_evt_t      last_q;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;
    logic [IW-1:0] intr_cnt;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .CLK        (CLK),
        .reset      (reset),
        .PS2CLK     (PS2CLK),
        .PS2DATA    (PS2DATA),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            push_q   <= 1'b0;
            push_evt <= '0;
        end else begin
            push_q <= 1'b0;
            if (byte_valid) begin
                // An E0 after any break prefix restarts the sequence as extended.
                if (byte_data == PS2_EXT && state != ST_EXT) begin
                    state <= ST_EXT;
                end else if (byte_data == PS2_BRK && state == ST_IDLE) begin
                    state <= ST_BRK;
                end else if (byte_data == PS2_BRK && state == ST_EXT) begin
                    state <= ST_EXT_BRK;
                end else begin
                    push_q        <= 1'b1;
                    push_evt.ext  <= (state == ST_EXT) || (state == ST_EXT_BRK);
                    push_evt.brk  <= (state == ST_BRK) || (state == ST_EXT_BRK);
                    push_evt.code <= byte_data;
                    state         <= ST_IDLE;
                end
            end
        end
    end

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty && evt.evt_ready;
    assign accept = push_q && (!full || pop);
    assign drop   = push_q && full && !pop;

    assign evt.evt_valid = !empty;
    assign evt.evt_data  = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= push_evt;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_q    <= '0;
            overflow  <= 1'b0;
            intr_cnt  <= '0;
            err_count <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                last_q <= mem[rd_ptr[AW-1:0]];
            end
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (accept)               intr_cnt <= IW'(INTR_CYCLES);
            else if (intr_cnt != '0)  intr_cnt <= intr_cnt - IW'(1);
            if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign INTRPT = (INTR_MODE == 1) ? evt.evt_valid : (intr_cnt != '0);
endmodule
